// File: rtl/des_round_pipe.sv
// DES round function as a 2-stage valid/ready pipeline.
// Stage 1 registers E(R)^K with L and R; stage 2 registers the swapped/unswapped round result.

module des_sbox_lut #(
  parameter logic [255:0] TABLE = '0
) (
  input  logic [1:6] addr,
  output logic [1:4] dout
);
  logic [5:0] idx;

  // Row-major table, entry 0 in the top nibble; {~idx,2'b00} == 4*(63-idx).
  assign idx  = {addr[1], addr[6], addr[2:5]};
  assign dout = TABLE[{~idx, 2'b00} +: 4];
endmodule

module SBox1 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox2 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox3 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox4 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox5 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox6 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox7 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
    u_lut (.addr(addr), .dout(dout));
endmodule

module SBox8 (input logic [1:6] addr, output logic [1:4] dout);
  des_sbox_lut #(.TABLE(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
    u_lut (.addr(addr), .dout(dout));
endmodule

module des_round_pipe #(
  parameter bit NO_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:32] l_in,
  input  logic [1:32] r_in,
  input  logic [1:48] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] l_out,
  output logic [1:32] r_out
);
  logic        s1_valid;
  logic        s2_valid;
  logic [1:48] s1_x;
  logic [1:32] s1_l;
  logic [1:32] s1_r;
  logic [1:48] e_r;
  logic [1:32] s_cat;
  logic [1:32] f;
  logic [1:32] l_next;
  logic [1:32] r_next;
  logic        adv2;

  assign e_r = {r_in[32], r_in[1:5], r_in[4:9], r_in[8:13], r_in[12:17],
                r_in[16:21], r_in[20:25], r_in[24:29], r_in[28:32], r_in[1]};

  SBox1 u_sbox1 (.addr(s1_x[1:6]),   .dout(s_cat[1:4]));
  SBox2 u_sbox2 (.addr(s1_x[7:12]),  .dout(s_cat[5:8]));
  SBox3 u_sbox3 (.addr(s1_x[13:18]), .dout(s_cat[9:12]));
  SBox4 u_sbox4 (.addr(s1_x[19:24]), .dout(s_cat[13:16]));
  SBox5 u_sbox5 (.addr(s1_x[25:30]), .dout(s_cat[17:20]));
  SBox6 u_sbox6 (.addr(s1_x[31:36]), .dout(s_cat[21:24]));
  SBox7 u_sbox7 (.addr(s1_x[37:42]), .dout(s_cat[25:28]));
  SBox8 u_sbox8 (.addr(s1_x[43:48]), .dout(s_cat[29:32]));

  assign f = {s_cat[16], s_cat[7],  s_cat[20], s_cat[21], s_cat[29], s_cat[12], s_cat[28], s_cat[17],
              s_cat[1],  s_cat[15], s_cat[23], s_cat[26], s_cat[5],  s_cat[18], s_cat[31], s_cat[10],
              s_cat[2],  s_cat[8],  s_cat[24], s_cat[14], s_cat[32], s_cat[27], s_cat[3],  s_cat[9],
              s_cat[19], s_cat[13], s_cat[30], s_cat[6],  s_cat[22], s_cat[11], s_cat[4],  s_cat[25]};

  always_comb begin
    l_next = s1_r;
    r_next = s1_l ^ f;
    if (NO_SWAP) begin
      l_next = s1_l ^ f;
      r_next = s1_r;
    end
  end

  assign adv2      = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv2;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_l     <= '0;
      s1_r     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x <= e_r ^ subkey;
        s1_l <= l_in;
        s1_r <= r_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      l_out    <= '0;
      r_out    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        l_out <= l_next;
        r_out <= r_next;
      end
    end
  end
endmodule

// File: tb/tb_des_round_pipe.sv
// Directed bench for des_round_pipe: vector table, streaming, backpressure, mid-flight reset.
module tb_des_round_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [1:32] l_in, r_in;
  logic [1:48] subkey;
  logic        in_ready, out_valid, in_ready_ns, out_valid_ns;
  logic [1:32] l_out, r_out, l_out_ns, r_out_ns;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_round_pipe #(.NO_SWAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .l_in(l_in), .r_in(r_in), .subkey(subkey), .out_valid(out_valid),
    .out_ready(out_ready), .l_out(l_out), .r_out(r_out));

  des_round_pipe #(.NO_SWAP(1'b1)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ns),
    .l_in(l_in), .r_in(r_in), .subkey(subkey), .out_valid(out_valid_ns),
    .out_ready(out_ready), .l_out(l_out_ns), .r_out(r_out_ns));

  int E_TBL [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                     16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int P_TBL [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [47:0] k;
    logic [31:0] xl;
    logic [31:0] xr;
  } vec_t;
  vec_t tv [16];

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    int row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TBL[i]];
    x = x ^ k;
    s = '0;
    for (int g = 0; g < 8; g++) begin
      six = x[47-6*g -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s = {s[27:0], 4'(SBOX[g][row*16+col])};
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TBL[i]];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i);
    l_in   = tv[i].l;
    r_in   = tv[i].r;
    subkey = tv[i].k;
  endtask

  task automatic check_res(input string name, input int i);
    check({name, "_l"}, 64'(l_out), 64'(tv[i].xl));
    check({name, "_r"}, 64'(r_out), 64'(tv[i].xr));
    check({name, "_ns_l"}, 64'(l_out_ns), 64'(tv[i].xr));
    check({name, "_ns_r"}, 64'(r_out_ns), 64'(tv[i].xl));
  endtask

  initial begin
    int nacc, idx, nr;
    logic acc;

    tv[0] = '{32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 32'hF0AAF0AA, 32'hEF4A6544};
    tv[1] = '{32'h0, 32'h0, 48'h0, 32'h0, 32'hD8D8DBBC};
    tv[2] = '{32'h0, 32'hFFFFFFFF, 48'h0, 32'hFFFFFFFF, 32'h38DBF9CB};
    for (int i = 3; i < 16; i++) begin
      tv[i].l  = $urandom;
      tv[i].r  = $urandom;
      tv[i].k  = {16'($urandom), 32'($urandom)};
      tv[i].xl = tv[i].r;
      tv[i].xr = tv[i].l ^ f_model(tv[i].r, tv[i].k);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    l_in = '0; r_in = '0; subkey = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_l_out", 64'(l_out), 64'd0);
    check("rst_r_out", 64'(r_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single operand, exact 2-stage latency
    apply(0);
    in_valid = 1'b1;
    check("single_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("single_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_ns_valid", 64'(out_valid_ns), 64'd1);
    check_res("single", 0);
    tick();
    check("single_drain", 64'(out_valid), 64'd0);

    // 16 back-to-back operands with out_ready held high
    apply(0);
    in_valid = 1'b1;
    for (int j = 0; j < 18; j++) begin
      check("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      if (j >= 1 && j <= 16) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        check_res("stream", j - 1);
      end
      if (j == 17) check("stream_drain", 64'(out_valid), 64'd0);
      if (j + 1 < 16) apply(j + 1);
      else in_valid = 1'b0;
    end

    // backpressure: only two operands fit, stage 2 holds
    out_ready = 1'b0;
    idx = 3;
    apply(idx);
    in_valid = 1'b1;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        nacc++;
        idx++;
        apply(idx);
      end
      if (c >= 1) begin
        check("bp_hold_l", 64'(l_out), 64'(tv[3].xl));
        check("bp_hold_r", 64'(r_out), 64'(tv[3].xr));
      end
    end
    check("bp_accepted", 64'(nacc), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    nr = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid && nr < 2) begin
        check_res("bp_drain", 3 + nr);
        nr++;
      end
      tick();
    end
    check("bp_drain_count", 64'(nr), 64'd2);
    check("bp_drain_empty", 64'(out_valid), 64'd0);

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    apply(5);
    in_valid = 1'b1;
    tick();
    apply(6);
    tick();
    tick();
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    check("mid_pre_in_ready", 64'(in_ready), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_async_valid", 64'(out_valid), 64'd0);
    check("mid_async_in_ready", 64'(in_ready), 64'd1);
    check("mid_async_l", 64'(l_out), 64'd0);
    check("mid_async_r", 64'(r_out), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_valid", 64'(out_valid), 64'd0);
      check("post_rst_l", 64'(l_out), 64'd0);
      check("post_rst_r", 64'(r_out), 64'd0);
    end
    apply(7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_lat1", 64'(out_valid), 64'd0);
    check("post_rst_lat1_l", 64'(l_out), 64'd0);
    tick();
    check("post_rst_new_valid", 64'(out_valid), 64'd1);
    check_res("post_rst_new", 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
